// File: rtl/pacman_pkg.sv
// Shared Pac-Man definitions: directions, transparent colour, tile geometry,
// LFSR constants and the breakable-wall placement FSM states.
package pacman_pkg;

   localparam logic [1:0] DIR_RIGHT = 2'd0;
   localparam logic [1:0] DIR_LEFT  = 2'd1;
   localparam logic [1:0] DIR_UP    = 2'd2;
   localparam logic [1:0] DIR_DOWN  = 2'd3;

   localparam logic [7:0] TRNS = 8'hFF;

   localparam int unsigned TILE_SHIFT = 4;

   // Galois form of x^16 + x^14 + x^13 + x^11 + 1
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef enum logic [2:0] {
      StIdle,
      StWait,
      StPick,
      StGen,
      StCheck,
      StRun
   } bw_state_e;

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
   endfunction

endpackage

// File: rtl/bwall_sprite_rom.sv
// Damage-stage bitmaps for a breakable wall: 0 intact, 1 cracked, 2 nearly broken.
// A set mask bit draws the stage colour, a clear bit is transparent.
module bwall_sprite_rom
   import pacman_pkg::*;
(
   input  logic [1:0] stage,
   input  logic [3:0] off_x,
   input  logic [3:0] off_y,
   output logic [7:0] rgb
);

   localparam logic [7:0] COL_INTACT  = 8'hB6;
   localparam logic [7:0] COL_CRACKED = 8'h92;
   localparam logic [7:0] COL_BROKEN  = 8'h49;

   localparam logic [15:0] CRACKED [16] = '{
      16'hFFFF, 16'hFFFF, 16'hFEFF, 16'hFC7F, 16'hF87F, 16'hF0FF, 16'hE1FF, 16'hC3FF,
      16'hFFFF, 16'hFF3F, 16'hFE1F, 16'hFC0F, 16'hFE1F, 16'hFF3F, 16'hFFFF, 16'hFFFF
   };

   localparam logic [15:0] BROKEN [16] = '{
      16'hE7E7, 16'hC3C3, 16'h8181, 16'h8001, 16'hC003, 16'hE007, 16'hC183, 16'h83C1,
      16'h87E1, 16'h83C1, 16'hC183, 16'hE007, 16'hC003, 16'h8001, 16'h8181, 16'hC3C3
   };

   logic [15:0] row;
   logic [7:0]  colour;

   // Row lookup by stage; leftmost pixel is the mask MSB
   always_comb begin
      row    = 16'hFFFF;
      colour = COL_INTACT;
      case (stage)
         2'd0: begin
            row    = 16'hFFFF;
            colour = COL_INTACT;
         end
         2'd1: begin
            row    = CRACKED[off_y];
            colour = COL_CRACKED;
         end
         default: begin
            row    = BROKEN[off_y];
            colour = COL_BROKEN;
         end
      endcase
      rgb = row[4'd15 - off_x] ? colour : TRNS;
   end

endmodule

// File: rtl/breakable_walls_array.sv
// Breakable wall array: random per-region placement handshaked with the maze
// checker, hit-point tracking on Pac-Man hits, timed respawn and sprite drawing.
module breakable_walls_array
   import pacman_pkg::*;
#(
   parameter int unsigned N_WALLS      = 8,
   parameter int unsigned MAX_HP       = 3,
   parameter int unsigned HP_BITS      = 3,
   parameter int unsigned COLS         = 4,
   parameter int unsigned X_BASE       = 6,
   parameter int unsigned X_STRIDE     = 6,
   parameter int unsigned Y_BASE       = 1,
   parameter int unsigned Y_STRIDE     = 10,
   parameter int unsigned RAND_BITS    = 3,
   parameter int unsigned MAX_RETRIES  = 15,
   parameter int unsigned REGEN_FRAMES = 600
) (
   input  logic                      clk,
   input  logic                      resetN,
   input  logic [10:0]               pixel_x,
   input  logic [10:0]               pixel_y,
   input  logic [10:0]               pm_pixel_x,
   input  logic [10:0]               pm_pixel_y,
   input  logic [1:0]                pm_direction,
   input  logic                      enter,
   input  logic                      start_of_frame,
   input  logic                      should_generate,
   input  logic                      is_valid,
   output logic                      bwalls_dr,
   output logic [7:0]                bwalls_RGB,
   output logic [N_WALLS-1:0][6:0]   bwall_tile_x,
   output logic [N_WALLS-1:0][6:0]   bwall_tile_y,
   output logic [N_WALLS-1:0]        bwall_alive,
   output logic                      gen_req,
   output logic [6:0]                generate_at_x,
   output logic [6:0]                generate_at_y,
   output logic                      gen_done,
   output logic [N_WALLS-1:0]        place_fail
);

   localparam int unsigned IDX_W = (N_WALLS > 1) ? $clog2(N_WALLS) : 1;

   bw_state_e           state;
   logic [15:0]         lfsr;
   logic [N_WALLS-1:0]  pending;
   logic [IDX_W-1:0]    cur;
   logic [7:0]          retry;
   logic [HP_BITS-1:0]  hp [N_WALLS];
   logic [15:0]         regen_cnt [N_WALLS];
   logic                enter_d;

   logic                pick_valid;
   logic [IDX_W-1:0]    pick_idx;
   logic [6:0]          cand_x, cand_y;
   logic [6:0]          pm_tx, pm_ty, tgt_x, tgt_y;
   logic                enter_rise;
   logic [6:0]          pix_tx, pix_ty;
   logic                drw_hit;
   logic [IDX_W-1:0]    drw_sel;
   logic [1:0]          drw_stage;
   logic [7:0]          rom_rgb;

   assign cand_x = 7'(X_BASE + (32'(cur) % COLS) * X_STRIDE + 32'(lfsr[RAND_BITS-1:0]));
   assign cand_y = 7'(Y_BASE + (32'(cur) / COLS) * Y_STRIDE + 32'(lfsr[8+RAND_BITS-1:8]));

   assign pm_tx      = 7'(pm_pixel_x >> TILE_SHIFT);
   assign pm_ty      = 7'(pm_pixel_y >> TILE_SHIFT);
   assign pix_tx     = 7'(pixel_x >> TILE_SHIFT);
   assign pix_ty     = 7'(pixel_y >> TILE_SHIFT);
   assign enter_rise = enter & ~enter_d;

   // Lowest-index pending wall is placed next
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      for (int i = int'(N_WALLS) - 1; i >= 0; i--) begin
         if (pending[i]) begin
            pick_valid = 1'b1;
            pick_idx   = IDX_W'(i);
         end
      end
   end

   // Tile in front of Pac-Man; 7-bit wrap, no clamp at the maze edge
   always_comb begin
      tgt_x = pm_tx;
      tgt_y = pm_ty;
      case (pm_direction)
         DIR_RIGHT: tgt_x = pm_tx + 7'd1;
         DIR_LEFT:  tgt_x = pm_tx - 7'd1;
         DIR_UP:    tgt_y = pm_ty - 7'd1;
         DIR_DOWN:  tgt_y = pm_ty + 7'd1;
      endcase
   end

   // Placement FSM, LFSR, hit handling and respawn timers
   always_ff @(posedge clk) begin
      if (resetN) begin
         state         <= StIdle;
         lfsr          <= LFSR_SEED;
         pending       <= '1;
         cur           <= '0;
         retry         <= '0;
         enter_d       <= 1'b0;
         gen_req       <= 1'b0;
         generate_at_x <= '0;
         generate_at_y <= '0;
         gen_done      <= 1'b0;
         place_fail    <= '0;
         bwall_tile_x  <= '0;
         bwall_tile_y  <= '0;
         for (int i = 0; i < int'(N_WALLS); i++) begin
            hp[i]        <= '0;
            regen_cnt[i] <= '0;
         end
      end else begin
         lfsr    <= lfsr_next(lfsr);
         enter_d <= enter;

         for (int i = 0; i < int'(N_WALLS); i++) begin
            if (enter_rise && hp[i] != '0 &&
                bwall_tile_x[i] == tgt_x && bwall_tile_y[i] == tgt_y) begin
               hp[i] <= hp[i] - HP_BITS'(1);
               if (hp[i] == HP_BITS'(1) && REGEN_FRAMES != 0) begin
                  regen_cnt[i] <= 16'(REGEN_FRAMES);
               end
            end else if (start_of_frame && regen_cnt[i] != 16'd0) begin
               regen_cnt[i] <= regen_cnt[i] - 16'd1;
               if (regen_cnt[i] == 16'd1) begin
                  pending[i] <= 1'b1;
               end
            end
         end

         case (state)
            StIdle: state <= StWait;
            StWait: if (should_generate) state <= StPick;
            StPick: begin
               if (!pick_valid) begin
                  gen_done <= 1'b1;
                  state    <= StRun;
               end else begin
                  cur   <= pick_idx;
                  retry <= '0;
                  state <= StGen;
               end
            end
            StGen: begin
               generate_at_x <= cand_x;
               generate_at_y <= cand_y;
               gen_req       <= 1'b1;
               state         <= StCheck;
            end
            StCheck: begin
               gen_req <= 1'b0;
               if (is_valid) begin
                  bwall_tile_x[cur] <= generate_at_x;
                  bwall_tile_y[cur] <= generate_at_y;
                  hp[cur]           <= HP_BITS'(MAX_HP);
                  pending[cur]      <= 1'b0;
                  state             <= StPick;
               end else if (retry == 8'(MAX_RETRIES)) begin
                  place_fail[cur] <= 1'b1;
                  pending[cur]    <= 1'b0;
                  state           <= StPick;
               end else begin
                  retry <= retry + 8'd1;
                  state <= StGen;
               end
            end
            StRun: if (|pending) state <= StPick;
            default: state <= StIdle;
         endcase
      end
   end

   // Liveness is simply non-zero hit points
   always_comb begin
      for (int i = 0; i < int'(N_WALLS); i++) begin
         bwall_alive[i] = hp[i] != '0;
      end
   end

   // Lowest-index live wall under the pixel wins
   always_comb begin
      drw_hit = 1'b0;
      drw_sel = '0;
      for (int i = int'(N_WALLS) - 1; i >= 0; i--) begin
         if (hp[i] != '0 && bwall_tile_x[i] == pix_tx && bwall_tile_y[i] == pix_ty) begin
            drw_hit = 1'b1;
            drw_sel = IDX_W'(i);
         end
      end
      if (hp[drw_sel] == HP_BITS'(MAX_HP)) begin
         drw_stage = 2'd0;
      end else if (hp[drw_sel] == HP_BITS'(1)) begin
         drw_stage = 2'd2;
      end else begin
         drw_stage = 2'd1;
      end
   end

   bwall_sprite_rom u_rom (
      .stage (drw_stage),
      .off_x (pixel_x[3:0]),
      .off_y (pixel_y[3:0]),
      .rgb   (rom_rgb)
   );

   // One-cycle registered pixel output
   always_ff @(posedge clk) begin
      if (resetN) begin
         bwalls_RGB <= TRNS;
      end else begin
         bwalls_RGB <= drw_hit ? rom_rgb : TRNS;
      end
   end

   assign bwalls_dr = bwalls_RGB != TRNS;

endmodule

// File: tb/tb_breakable_walls_array.sv
module tb_breakable_walls_array;
   import pacman_pkg::*;

   logic        clk = 1'b0;
   logic        resetN = 1'b1;
   logic [10:0] pixel_x = '0, pixel_y = '0, pm_pixel_x = '0, pm_pixel_y = '0;
   logic [1:0]  pm_direction = DIR_RIGHT;
   logic        enter = 1'b0, start_of_frame = 1'b0, should_generate = 1'b0;
   logic        is_valid;

   // Main instance (REGEN_FRAMES = 600)
   logic            bwalls_dr, gen_req, gen_done;
   logic [7:0]      bwalls_RGB, bwall_alive, place_fail;
   logic [7:0][6:0] bwall_tile_x, bwall_tile_y;
   logic [6:0]      generate_at_x, generate_at_y;
   // Fast-respawn instance (REGEN_FRAMES = 4)
   logic            dr_r, gen_req_r, done_r;
   logic [7:0]      rgb_r, alive_r, pf_r;
   logic [7:0][6:0] tx_r, ty_r;
   logic [6:0]      gax_r, gay_r;
   // No-respawn instance (REGEN_FRAMES = 0)
   logic            dr_z, gen_req_z, done_z;
   logic [7:0]      rgb_z, alive_z, pf_z;
   logic [7:0][6:0] tx_z, ty_z;
   logic [6:0]      gax_z, gay_z;

   breakable_walls_array dut (
      .clk(clk), .resetN(resetN), .pixel_x(pixel_x), .pixel_y(pixel_y),
      .pm_pixel_x(pm_pixel_x), .pm_pixel_y(pm_pixel_y), .pm_direction(pm_direction),
      .enter(enter), .start_of_frame(start_of_frame), .should_generate(should_generate),
      .is_valid(is_valid), .bwalls_dr(bwalls_dr), .bwalls_RGB(bwalls_RGB),
      .bwall_tile_x(bwall_tile_x), .bwall_tile_y(bwall_tile_y), .bwall_alive(bwall_alive),
      .gen_req(gen_req), .generate_at_x(generate_at_x), .generate_at_y(generate_at_y),
      .gen_done(gen_done), .place_fail(place_fail)
   );

   breakable_walls_array #(.REGEN_FRAMES(4)) dut_r (
      .clk(clk), .resetN(resetN), .pixel_x(pixel_x), .pixel_y(pixel_y),
      .pm_pixel_x(pm_pixel_x), .pm_pixel_y(pm_pixel_y), .pm_direction(pm_direction),
      .enter(enter), .start_of_frame(start_of_frame), .should_generate(should_generate),
      .is_valid(is_valid), .bwalls_dr(dr_r), .bwalls_RGB(rgb_r),
      .bwall_tile_x(tx_r), .bwall_tile_y(ty_r), .bwall_alive(alive_r),
      .gen_req(gen_req_r), .generate_at_x(gax_r), .generate_at_y(gay_r),
      .gen_done(done_r), .place_fail(pf_r)
   );

   breakable_walls_array #(.REGEN_FRAMES(0)) dut_z (
      .clk(clk), .resetN(resetN), .pixel_x(pixel_x), .pixel_y(pixel_y),
      .pm_pixel_x(pm_pixel_x), .pm_pixel_y(pm_pixel_y), .pm_direction(pm_direction),
      .enter(enter), .start_of_frame(start_of_frame), .should_generate(should_generate),
      .is_valid(is_valid), .bwalls_dr(dr_z), .bwalls_RGB(rgb_z),
      .bwall_tile_x(tx_z), .bwall_tile_y(ty_z), .bwall_alive(alive_z),
      .gen_req(gen_req_z), .generate_at_x(gax_z), .generate_at_y(gay_z),
      .gen_done(done_z), .place_fail(pf_z)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Checker model: tracks which wall is being placed from the handshake
   logic       fail2 = 1'b0;
   int         widx = 0, rej = 0, gen2 = 0;
   logic [6:0] cap_x [8];
   logic [6:0] cap_y [8];
   logic       mon_z = 1'b0, z_seen = 1'b0;

   assign is_valid = !(fail2 && widx == 2);

   always @(posedge clk) begin
      if (resetN) begin
         widx <= 0;
         rej  <= 0;
         gen2 <= 0;
      end else if (gen_req) begin
         if (widx == 2) gen2 <= gen2 + 1;
         if (is_valid) begin
            if (widx < 8) begin
               cap_x[widx] <= generate_at_x;
               cap_y[widx] <= generate_at_y;
            end
            widx <= widx + 1;
            rej  <= 0;
         end else if (rej == 15) begin
            widx <= widx + 1;
            rej  <= 0;
         end else begin
            rej <= rej + 1;
         end
      end
      if (mon_z && gen_req_z) z_seen <= 1'b1;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      resetN = 1'b1;
      tick;
      resetN = 1'b0;
      tick;
   endtask

   task automatic run_place(input string tag, input int exp_lat);
      int cnt;
      cnt = 0;
      should_generate = 1'b1;
      tick;
      should_generate = 1'b0;
      while (!gen_done && cnt < 300) begin
         tick;
         cnt++;
      end
      check(tag, 64'(cnt), 64'(exp_lat));
   endtask

   task automatic hit_pulse;
      enter = 1'b1;
      tick;
      enter = 1'b0;
      tick;
   endtask

   task automatic frame_pulse;
      start_of_frame = 1'b1;
      tick;
      start_of_frame = 1'b0;
      tick;
   endtask

   task automatic draw_chk(input string tag, input logic [6:0] tx, input logic [6:0] ty,
                           input logic [3:0] ox, input logic [3:0] oy, input logic [7:0] exp);
      pixel_x = {tx, ox};
      pixel_y = {ty, oy};
      tick;
      check(tag, 64'(bwalls_RGB), 64'(exp));
      check({tag, "_dr"}, 64'(bwalls_dr), 64'(exp != TRNS));
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int  cnt;
      logic seen;
      logic [6:0] nx, ny;

      // Reset state
      tick;
      do_reset;
      check("rst_alive", 64'(bwall_alive), 64'h0);
      check("rst_done", 64'(gen_done), 64'h0);
      check("rst_req", 64'(gen_req), 64'h0);
      check("rst_fail", 64'(place_fail), 64'h0);
      check("rst_tile_x", 64'(bwall_tile_x), 64'h0);
      check("rst_tile_y", 64'(bwall_tile_y), 64'h0);
      check("rst_rgb", 64'(bwalls_RGB), 64'(TRNS));
      check("rst_dr", 64'(bwalls_dr), 64'h0);

      // All candidates accepted: 1 + 8*3 + 1 edges
      run_place("place_lat", 25);
      check("place_alive", 64'(bwall_alive), 64'hFF);
      check("place_fail0", 64'(place_fail), 64'h0);
      check("w5_x_range", 64'(bwall_tile_x[5] >= 7'd12 && bwall_tile_x[5] <= 7'd19), 64'h1);
      check("w5_y_range", 64'(bwall_tile_y[5] >= 7'd11 && bwall_tile_y[5] <= 7'd18), 64'h1);
      check("w0_x_range", 64'(cap_x[0] >= 7'd6 && cap_x[0] <= 7'd13), 64'h1);
      check("w0_y_range", 64'(cap_y[0] >= 7'd1 && cap_y[0] <= 7'd8), 64'h1);
      check("w0_tile_x", 64'(bwall_tile_x[0]), 64'(cap_x[0]));
      check("w0_tile_y", 64'(bwall_tile_y[0]), 64'(cap_y[0]));

      // Drawing and hits on wall 0, Pac-Man one tile to its left
      draw_chk("draw_far", 7'd0, 7'd0, 4'd4, 4'd4, TRNS);
      draw_chk("draw_st0", cap_x[0], cap_y[0], 4'd4, 4'd4, 8'hB6);
      pm_pixel_x   = {cap_x[0] - 7'd1, 4'd0};
      pm_pixel_y   = {cap_y[0], 4'd0};
      pm_direction = DIR_LEFT;
      hit_pulse;
      draw_chk("miss_left", cap_x[0], cap_y[0], 4'd4, 4'd4, 8'hB6);
      pm_direction = DIR_RIGHT;
      hit_pulse;
      check("hit1_alive", 64'(bwall_alive[0]), 64'h1);
      draw_chk("draw_st1", cap_x[0], cap_y[0], 4'd4, 4'd4, 8'h92);
      draw_chk("draw_st1_hole", cap_x[0], cap_y[0], 4'd5, 4'd4, TRNS);
      enter = 1'b1;
      repeat (100) tick;
      enter = 1'b0;
      tick;
      check("hold_alive", 64'(bwall_alive[0]), 64'h1);
      draw_chk("draw_st2", cap_x[0], cap_y[0], 4'd0, 4'd4, 8'h49);
      draw_chk("draw_st2_hole", cap_x[0], cap_y[0], 4'd4, 4'd4, TRNS);
      hit_pulse;
      check("kill_alive", 64'(bwall_alive[0]), 64'h0);
      check("kill_alive_r", 64'(alive_r[0]), 64'h0);
      check("kill_alive_z", 64'(alive_z[0]), 64'h0);
      draw_chk("draw_dead", cap_x[0], cap_y[0], 4'd0, 4'd4, TRNS);

      // Respawn after 4 frames on the fast instance only
      mon_z = 1'b1;
      repeat (3) frame_pulse;
      check("regen_early", 64'(alive_r[0]), 64'h0);
      start_of_frame = 1'b1;
      tick;
      start_of_frame = 1'b0;
      cnt  = 0;
      seen = 1'b0;
      while (!seen && cnt < 20) begin
         tick;
         cnt++;
         seen = gen_req_r;
      end
      check("regen_req", 64'(seen), 64'h1);
      nx = gax_r;
      ny = gay_r;
      cnt = 0;
      while (!alive_r[0] && cnt < 20) begin
         tick;
         cnt++;
      end
      check("regen_alive_r", 64'(alive_r[0]), 64'h1);
      check("regen_alive_main", 64'(bwall_alive[0]), 64'h0);
      pixel_x = {nx, 4'd4};
      pixel_y = {ny, 4'd4};
      tick;
      check("regen_full_hp", 64'(rgb_r), 64'hB6);
      repeat (20) frame_pulse;
      check("noregen_alive_z", 64'(alive_z[0]), 64'h0);
      check("noregen_req_z", 64'(z_seen), 64'h0);
      check("noregen_alive_main", 64'(bwall_alive[0]), 64'h0);

      // Wall 2 always rejected: 16 checks then abandoned
      do_reset;
      fail2 = 1'b1;
      run_place("fail_lat", 55);
      fail2 = 1'b0;
      check("fail_req_cnt", 64'(gen2), 64'd16);
      check("fail_mask", 64'(place_fail), 64'h04);
      check("fail_alive", 64'(bwall_alive), 64'hFB);
      check("fail_tile", 64'(bwall_tile_x[2]), 64'h0);

      // Reset during CHECK of wall 3
      do_reset;
      should_generate = 1'b1;
      tick;
      should_generate = 1'b0;
      cnt = 0;
      while (!(gen_req && widx == 3) && cnt < 100) begin
         tick;
         cnt++;
      end
      check("mid_reach_w3", 64'(gen_req && widx == 3), 64'h1);
      resetN = 1'b1;
      tick;
      resetN = 1'b0;
      check("mid_alive", 64'(bwall_alive), 64'h0);
      check("mid_tile", 64'(bwall_tile_x), 64'h0);
      check("mid_req", 64'(gen_req), 64'h0);
      check("mid_done", 64'(gen_done), 64'h0);
      check("mid_rgb", 64'(bwalls_RGB), 64'(TRNS));
      seen = 1'b0;
      repeat (5) begin
         tick;
         seen = seen | gen_req;
      end
      check("mid_idle", 64'(seen), 64'h0);
      run_place("rerun_lat", 25);
      check("rerun_alive", 64'(bwall_alive), 64'hFF);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
